// File: rtl/apb_subsystem_top.sv
// apb_subsystem_top: CPU-facing APB master bridge driving a 32-entry register-file slave
// over an internal APB bus scope (APB_Protocol_Bus). Transfers issue back-to-back forever.
// Optional feature macro: APB_STRB_EN -- when defined, byte-lane write strobes are honoured;
// when undefined, PSTRB is forced all-ones and every valid write updates the full word.

module apb_subsystem_top #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned PROT_SIZE = 3,
    parameter int unsigned STRB_SIZE = DATA_SIZE/8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 MWRITE,
    input  logic [PROT_SIZE-1:0] MPROT,
    input  logic [ADDR_SIZE-1:0] MADDR,
    input  logic [DATA_SIZE-1:0] MWDATA,
    input  logic [STRB_SIZE-1:0] MSTRB,
    output logic [DATA_SIZE-1:0] MRDATA,
    output logic                 MSLVERR
);

    localparam int unsigned DEPTH = 32;
    localparam int unsigned IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_psel;
    logic                   w_penable;
    logic                   w_load;
    logic                   w_done;

    logic                   r_pwrite;
    logic [ADDR_SIZE-1:0]   r_paddr;
    logic [DATA_SIZE-1:0]   r_pwdata;
    logic [STRB_SIZE-1:0]   r_pstrb;
    logic [PROT_SIZE-1:0]   r_pprot;

    logic [DATA_SIZE-1:0]   r_mrdata;
    logic                   r_mslverr;

    logic                   w_pready;
    logic                   w_pslverr;
    logic [DATA_SIZE-1:0]   w_prdata;

    assign w_pready  = APB_Protocol_Bus.PREADY;
    assign w_pslverr = APB_Protocol_Bus.PSLVERR;
    assign w_prdata  = APB_Protocol_Bus.PRDATA;

    assign MRDATA  = r_mrdata;
    assign MSLVERR = r_mslverr;

    // Master state register
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Master next-state and bus control decode
    always_comb begin
        w_next_state = r_state;
        w_psel       = 1'b0;
        w_penable    = 1'b0;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_SETUP;
                w_load       = 1'b1;
            end
            ST_SETUP: begin
                w_psel       = 1'b1;
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (w_pready) begin
                    w_next_state = ST_SETUP;
                    w_load       = 1'b1;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the CPU request on every edge that enters SETUP; held through ACCESS
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
        end else if (w_load) begin
            r_pwrite <= MWRITE;
            r_paddr  <= MADDR;
            r_pwdata <= MWDATA;
`ifdef APB_STRB_EN
            r_pstrb  <= MSTRB;
`else
            r_pstrb  <= '1;
`endif
            r_pprot  <= MPROT;
        end
    end

`ifndef APB_STRB_EN
    // Strobes are ignored in this build; fold them so the input is still consumed
    logic w_unused_strb;
    assign w_unused_strb = ^MSTRB;
`endif

    // Return status and read data to the CPU on transfer completion
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_mrdata  <= '0;
            r_mslverr <= 1'b0;
        end else if (w_done) begin
            r_mslverr <= w_pslverr;
            if (!r_pwrite) begin
                r_mrdata <= w_pslverr ? '0 : w_prdata;
            end
        end
    end

    // Internal APB bus and its single register-file slave
    if (1'b1) begin : APB_Protocol_Bus
        logic                 PSEL;
        logic                 PENABLE;
        logic                 PWRITE;
        logic [ADDR_SIZE-1:0] PADDR;
        logic [DATA_SIZE-1:0] PWDATA;
        logic [STRB_SIZE-1:0] PSTRB;
        logic [PROT_SIZE-1:0] PPROT;
        logic [DATA_SIZE-1:0] PRDATA;
        logic                 PREADY;
        logic                 PSLVERR;

        logic [DATA_SIZE-1:0] r_mem [DEPTH];
        logic [IDX_W-1:0]     w_idx;
        logic                 w_access;
        logic                 w_in_range;
        logic [DATA_SIZE-1:0] w_bmask;
        logic                 w_unused_prot;

        assign PSEL    = w_psel;
        assign PENABLE = w_penable;
        assign PWRITE  = r_pwrite;
        assign PADDR   = r_paddr;
        assign PWDATA  = r_pwdata;
        assign PSTRB   = r_pstrb;
        assign PPROT   = r_pprot;

        // Protection attributes travel on the bus but the slave does not act on them
        assign w_unused_prot = ^PPROT;

        assign w_idx      = PADDR[IDX_W-1:0];
        assign w_access   = PSEL & PENABLE;
        assign w_in_range = (PADDR < ADDR_SIZE'(DEPTH));
        assign PREADY     = w_access;
        assign PSLVERR    = w_access & ~w_in_range;
        assign PRDATA     = (w_access && w_in_range) ? r_mem[w_idx] : '0;

        // Expand byte strobes to a bit mask
        for (genvar g = 0; g < STRB_SIZE; g++) begin : g_bmask
            assign w_bmask[g*8 +: 8] = {8{PSTRB[g]}};
        end

        // Register file: cleared on reset, byte-masked write on a ready in-range access
        always_ff @(posedge PCLK) begin
            if (PRESETn) begin
                r_mem <= '{default: '0};
            end else if (w_access && PREADY && PWRITE && w_in_range) begin
                r_mem[w_idx] <= (r_mem[w_idx] & ~w_bmask) | (PWDATA & w_bmask);
            end
        end
    end

endmodule

// File: tb/tb_apb_subsystem_top.sv
// Directed bench for apb_subsystem_top: reset, full/partial writes, out-of-range errors,
// forced wait states and reset mid-transfer.

module tb_apb_subsystem_top;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        MWRITE;
    logic [2:0]  MPROT;
    logic [31:0] MADDR;
    logic [31:0] MWDATA;
    logic [3:0]  MSTRB;
    logic [31:0] MRDATA;
    logic        MSLVERR;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp5;
    logic [31:0] exp6;

    apb_subsystem_top dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .MWRITE  (MWRITE),
        .MPROT   (MPROT),
        .MADDR   (MADDR),
        .MWDATA  (MWDATA),
        .MSTRB   (MSTRB),
        .MRDATA  (MRDATA),
        .MSLVERR (MSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
        MWRITE = wr;
        MADDR  = addr;
        MWDATA = data;
        MSTRB  = strb;
        MPROT  = 3'b010;
    endtask

    // Advance until the bus is in SETUP carrying the request currently driven
    task automatic wait_setup(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge PCLK); #1;
            n++;
        end while (!(dut.APB_Protocol_Bus.PSEL && !dut.APB_Protocol_Bus.PENABLE) && n < 20);
        if (n >= 20) begin
            checks++;
            errors++;
            $error("FAIL %s_setup_timeout: observed=no SETUP expected=SETUP within 20 cycles", tag);
        end
    endtask

    // Run one transfer to completion; returns #1 after the completing edge
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        int n;
        set_req(wr, addr, data, strb);
        wait_setup(tag);
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!(dut.APB_Protocol_Bus.PENABLE && dut.APB_Protocol_Bus.PREADY) && n < 20);
        if (n >= 20) begin
            checks++;
            errors++;
            $error("FAIL %s_done_timeout: observed=no completion expected=completion within 20 cycles", tag);
        end
        @(posedge PCLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=simulation still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef APB_STRB_EN
        exp5 = 32'h7825_4500;
        exp6 = 32'h0000_4535;
`else
        exp5 = 32'h7825_4535;
        exp6 = 32'h7825_4535;
`endif
        PRESETn = 1'b1;
        set_req(1'b0, 32'd0, 32'd0, 4'h0);

        // Reset held for two cycles
        repeat (2) @(posedge PCLK);
        #1;
        check("reset_mrdata",  MRDATA, 32'h0);
        check("reset_mslverr", 32'(MSLVERR), 32'd0);
        check("reset_psel",    32'(dut.APB_Protocol_Bus.PSEL), 32'd0);

        // First SETUP one cycle after release, carrying the driven request
        set_req(1'b1, 32'd2, 32'h0123_4567, 4'hF);
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        check("first_setup_psel",    32'(dut.APB_Protocol_Bus.PSEL), 32'd1);
        check("first_setup_penable", 32'(dut.APB_Protocol_Bus.PENABLE), 32'd0);
        check("first_setup_paddr",   dut.APB_Protocol_Bus.PADDR, 32'd2);

        // Full-word writes
        xfer("wr2", 1'b1, 32'd2, 32'h0123_4567, 4'hF);
        check("wr2_err", 32'(MSLVERR), 32'd0);
        xfer("wr3", 1'b1, 32'd3, 32'h89AB_CDEF, 4'hF);
        check("wr3_err", 32'(MSLVERR), 32'd0);
        xfer("wr4", 1'b1, 32'd4, 32'h0075_4123, 4'hF);
        check("wr4_err", 32'(MSLVERR), 32'd0);
        check("wr4_mrdata_hold", MRDATA, 32'h0);

        xfer("rd2", 1'b0, 32'd2, 32'h0, 4'h0);
        check("rd2_data", MRDATA, 32'h0123_4567);
        xfer("rd3", 1'b0, 32'd3, 32'h0, 4'h0);
        check("rd3_data", MRDATA, 32'h89AB_CDEF);
        xfer("rd4", 1'b0, 32'd4, 32'h0, 4'h0);
        check("rd4_data", MRDATA, 32'h0075_4123);
        check("rd4_err",  32'(MSLVERR), 32'd0);

        // Partial-strobe writes
        xfer("wr5", 1'b1, 32'd5, 32'h7825_4535, 4'b1110);
        xfer("wr6", 1'b1, 32'd6, 32'h7825_4535, 4'b0011);
        check("wr6_mrdata_hold", MRDATA, 32'h0075_4123);
        xfer("rd5", 1'b0, 32'd5, 32'h0, 4'h0);
        check("rd5_data", MRDATA, exp5);
        xfer("rd6", 1'b0, 32'd6, 32'h0, 4'h0);
        check("rd6_data", MRDATA, exp6);

        // Out-of-range accesses
        xfer("wr35", 1'b1, 32'd35, 32'hDEAD_BEEF, 4'hF);
        check("wr35_err",         32'(MSLVERR), 32'd1);
        check("wr35_mrdata_hold", MRDATA, exp6);
        xfer("rd3_after35", 1'b0, 32'd3, 32'h0, 4'h0);
        check("rd3_after35_data", MRDATA, 32'h89AB_CDEF);
        check("rd3_after35_err",  32'(MSLVERR), 32'd0);
        xfer("rd31", 1'b0, 32'd31, 32'h0, 4'h0);
        check("rd31_err",  32'(MSLVERR), 32'd0);
        check("rd31_data", MRDATA, 32'h0);
        xfer("rd60", 1'b0, 32'd60, 32'h0, 4'h0);
        check("rd60_err",  32'(MSLVERR), 32'd1);
        check("rd60_data", MRDATA, 32'h0);

        // Wait states: hold PREADY low for 8 ACCESS cycles on a read of 5
        set_req(1'b0, 32'd5, 32'h0, 4'h0);
        wait_setup("stall");
        force dut.APB_Protocol_Bus.PREADY = 1'b0;
        MADDR = 32'd9;
        for (int c = 0; c < 8; c++) begin
            @(posedge PCLK); #1;
            check("stall_penable", 32'(dut.APB_Protocol_Bus.PENABLE), 32'd1);
            check("stall_paddr",   dut.APB_Protocol_Bus.PADDR, 32'd5);
            check("stall_mrdata",  MRDATA, 32'h0);
            check("stall_mslverr", 32'(MSLVERR), 32'd1);
        end
        release dut.APB_Protocol_Bus.PREADY;
        set_req(1'b0, 32'd5, 32'h0, 4'h0);
        @(posedge PCLK); #1;
        check("stall_done_data", MRDATA, exp5);
        check("stall_done_err",  32'(MSLVERR), 32'd0);
        check("stall_done_setup", 32'(dut.APB_Protocol_Bus.PENABLE), 32'd0);

        // Reset asserted during ACCESS of a write to 7
        set_req(1'b1, 32'd7, 32'hCAFE_F00D, 4'hF);
        wait_setup("rst7");
        @(posedge PCLK); #1;
        check("rst7_in_access", 32'(dut.APB_Protocol_Bus.PENABLE), 32'd1);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        check("rst7_psel_idle", 32'(dut.APB_Protocol_Bus.PSEL), 32'd0);
        check("rst7_mrdata",    MRDATA, 32'h0);
        set_req(1'b0, 32'd7, 32'h0, 4'h0);
        PRESETn = 1'b0;
        xfer("rd7", 1'b0, 32'd7, 32'h0, 4'h0);
        check("rd7_data", MRDATA, 32'h0);
        check("rd7_err",  32'(MSLVERR), 32'd0);
        xfer("rd2_cleared", 1'b0, 32'd2, 32'h0, 4'h0);
        check("rd2_cleared_data", MRDATA, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
